snake_mover: RTL and testbench

//  Movement/growth engine for one snake; core instantiates two (snake1, snake2).
//  On each game-tick pulse it:
//   - computes the next head cell from the buffered direction;
//   - checks wall and self collision;
//   - shifts the body and grows when the head lands on food1 or food2.

---
 rtl/snake_mover_if.sv | 28 ++
 rtl/snake_mover.sv | 180 ++++++++++++++++++
 tb/tb_snake_mover.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/snake_mover_if.sv
// Bundle of the game-side signals of one snake_mover: tick, direction
// request, food cells in; packed body, score and status flags out.
interface snake_mover_if #(
  parameter int max_len         = 16,
  parameter int num_len         = 10,
  parameter int max_len_bit_len = 4
);
  logic                         step;
  logic [1:0]                   dir_in;
  logic                         dir_valid;
  logic [num_len-1:0]           food1;
  logic [num_len-1:0]           food2;
  logic [max_len*num_len-1:0]   snake;
  logic [max_len_bit_len-1:0]   score;
  logic                         ate;
  logic                         dead;
  logic                         busy;

  modport master (
    output step, dir_in, dir_valid, food1, food2,
    input  snake, score, ate, dead, busy
  );

  modport slave (
    input  step, dir_in, dir_valid, food1, food2,
    output snake, score, ate, dead, busy
  );
endinterface

// File: rtl/snake_mover.sv
// Movement/growth engine for one snake. On each game tick the head advances
// one cell in the buffered direction, collisions are checked and the body
// shifts (growing when the new head lands on a food cell).
// Optional feature: define SNAKE_WRAP_EN to make the grid edges wrap around
// instead of acting as walls.
module snake_mover #(
  parameter int                 max_len         = 16,
  parameter int                 num_len         = 10,
  parameter int                 max_len_bit_len = 4,
  parameter int                 width           = 32,
  parameter int                 height          = 24,
  parameter logic [num_len-1:0] init_head       = 10'd204,
  parameter int                 init_len        = 3
) (
  input  logic          clk,
  input  logic          rst,
  snake_mover_if.slave  bus
);

  localparam int SW      = max_len_bit_len;
  localparam int NW      = num_len + 1;
  localparam int LEN_MAX = (max_len < (2**max_len_bit_len) - 1) ? max_len
                                                                  : (2**max_len_bit_len) - 1;
  localparam logic [num_len-1:0] EMPTY = '1;
  localparam logic [NW-1:0]      ONE   = NW'(1);
  localparam logic [1:0] DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_COMMIT} state_t;

  state_t                          r_state, w_state_nxt;
  logic [max_len-1:0][num_len-1:0] r_body, w_shift;
  logic [SW-1:0]                   r_score, w_new_score;
  logic [1:0]                      r_dir, r_pending;
  logic                            r_ate, r_dead;
  logic [num_len-1:0]              r_next, w_next, w_head;
  logic                            r_wall, r_grow, w_wall, w_grow, w_hit, w_reverse;
  logic [NW-1:0]                   w_row, w_col, w_nrow, w_ncol;

  function automatic logic [max_len-1:0][num_len-1:0] f_init_body();
    logic [max_len-1:0][num_len-1:0] body;
    for (int j = 0; j < max_len; j++)
      body[j] = (j < init_len) ? init_head - num_len'(j) : EMPTY;
    return body;
  endfunction

  // Length after eating: one more, clamped to the largest representable length.
  function automatic logic [SW-1:0] f_sat_inc(input logic [SW-1:0] len);
    if (int'(len) >= LEN_MAX) return SW'(LEN_MAX);
    return len + SW'(1);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; ticks arriving while busy or dead are dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.step && !r_dead) w_state_nxt = S_CALC;
      S_CALC:   w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next head cell from current head and committed direction (one extra bit
  // of headroom so row/col 0 minus one cannot alias).
  always_comb begin
    w_head = r_body[0];
    w_row  = NW'({1'b0, w_head} / NW'(width));
    w_col  = NW'({1'b0, w_head} % NW'(width));
    w_nrow = w_row;
    w_ncol = w_col;
    w_wall = 1'b0;
    case (r_dir)
      DIR_UP: begin
        if (w_row == '0) begin
`ifdef SNAKE_WRAP_EN
          w_nrow = NW'(height - 1);
`else
          w_wall = 1'b1;
`endif
        end else w_nrow = w_row - ONE;
      end
      DIR_DOWN: begin
        if (w_row == NW'(height - 1)) begin
`ifdef SNAKE_WRAP_EN
          w_nrow = '0;
`else
          w_wall = 1'b1;
`endif
        end else w_nrow = w_row + ONE;
      end
      DIR_LEFT: begin
        if (w_col == '0) begin
`ifdef SNAKE_WRAP_EN
          w_ncol = NW'(width - 1);
`else
          w_wall = 1'b1;
`endif
        end else w_ncol = w_col - ONE;
      end
      default: begin
        if (w_col == NW'(width - 1)) begin
`ifdef SNAKE_WRAP_EN
          w_ncol = '0;
`else
          w_wall = 1'b1;
`endif
        end else w_ncol = w_col + ONE;
      end
    endcase
    w_next = num_len'(w_nrow * NW'(width) + w_ncol);
    // All-ones food marks an absent food item and must never match.
    w_grow = ((bus.food1 != EMPTY) && (w_next == bus.food1)) ||
             ((bus.food2 != EMPTY) && (w_next == bus.food2));
  end

  // Self collision and the shifted body; a growing move keeps the tail cell
  // occupied, so it is included in the compare.
  always_comb begin
    w_hit = 1'b0;
    for (int j = 0; j < max_len; j++) begin
      if (((j < int'(r_score) - 1) || (r_grow && (j < int'(r_score)))) && (r_body[j] == r_next))
        w_hit = 1'b1;
    end
    w_new_score = r_grow ? f_sat_inc(r_score) : r_score;
    w_shift[0]  = r_next;
    for (int j = 1; j < max_len; j++) w_shift[j] = r_body[j-1];
    for (int j = 0; j < max_len; j++)
      if (j >= int'(w_new_score)) w_shift[j] = EMPTY;
  end

  assign w_reverse = (bus.dir_in == {r_dir[1], ~r_dir[0]});

  // Direction buffer, move computation and body/score update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_body    <= f_init_body();
      r_score   <= SW'(init_len);
      r_ate     <= 1'b0;
      r_dead    <= 1'b0;
      r_dir     <= DIR_RIGHT;
      r_pending <= DIR_RIGHT;
      r_next    <= '0;
      r_wall    <= 1'b0;
      r_grow    <= 1'b0;
    end else begin
      r_ate <= 1'b0;
      if (bus.dir_valid && !w_reverse) r_pending <= bus.dir_in;
      case (r_state)
        S_IDLE: if (bus.step && !r_dead) r_dir <= r_pending;
        S_CALC: begin
          r_next <= w_next;
          r_wall <= w_wall;
          r_grow <= w_grow;
        end
        S_COMMIT: begin
          if (w_hit || r_wall) r_dead <= 1'b1;
          else begin
            r_body  <= w_shift;
            r_score <= w_new_score;
            r_ate   <= r_grow;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.snake = r_body;
  assign bus.score = r_score;
  assign bus.ate   = r_ate;
  assign bus.dead  = r_dead;
  assign bus.busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_snake_mover.sv
// Directed plus randomized bench for snake_mover against a queue-based model
// of the snake body.
module tb_snake_mover;

  localparam int W = 32, H = 24, LEN_MAX = 15, NL = 10, ML = 16;
`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snake_mover_if #(.max_len(ML), .num_len(NL), .max_len_bit_len(4)) sm ();
  snake_mover dut (.clk(clk), .rst(rst), .bus(sm));

  int checks = 0;
  int errors = 0;

  // Reference model: body as a queue of cell numbers, head first.
  int body[$];
  int mdir, mpend;
  bit mdead;
  bit exp_ate;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] exp_vec();
    logic [159:0] v;
    v = '1;
    for (int j = 0; j < body.size(); j++) v[j*NL +: NL] = NL'(body[j]);
    return v;
  endfunction

  function automatic int m_next(input int d, output bit wall);
    int r, c;
    r = body[0] / W;
    c = body[0] % W;
    wall = 1'b0;
    case (d)
      0: if (r == 0)     begin if (WRAP) r = H - 1; else wall = 1'b1; end else r = r - 1;
      1: if (r == H - 1) begin if (WRAP) r = 0;     else wall = 1'b1; end else r = r + 1;
      2: if (c == 0)     begin if (WRAP) c = W - 1; else wall = 1'b1; end else c = c - 1;
      default: if (c == W - 1) begin if (WRAP) c = 0; else wall = 1'b1; end else c = c + 1;
    endcase
    return r * W + c;
  endfunction

  task automatic m_reset();
    body = {204, 203, 202};
    mdir = 3; mpend = 3; mdead = 1'b0; exp_ate = 1'b0;
  endtask

  task automatic m_move();
    int nxt, lim;
    bit wall, grow, hit;
    exp_ate = 1'b0;
    if (mdead) return;
    mdir = mpend;
    nxt  = m_next(mdir, wall);
    grow = (int'(sm.food1) != 1023 && nxt == int'(sm.food1)) ||
           (int'(sm.food2) != 1023 && nxt == int'(sm.food2));
    lim  = grow ? body.size() : body.size() - 1;
    hit  = 1'b0;
    for (int j = 0; j < lim; j++) if (body[j] == nxt) hit = 1'b1;
    if (wall || hit) mdead = 1'b1;
    else begin
      body.push_front(nxt);
      if (!grow || body.size() > LEN_MAX) void'(body.pop_back());
      exp_ate = grow;
    end
  endtask

  task automatic check_state(input string tag, input bit busy_exp);
    chk({tag, ".snake"}, sm.snake, exp_vec());
    chk({tag, ".score"}, sm.score, body.size());
    chk({tag, ".dead"},  sm.dead,  mdead);
    chk({tag, ".ate"},   sm.ate,   exp_ate);
    chk({tag, ".busy"},  sm.busy,  busy_exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    check_state("reset", 1'b0);
  endtask

  task automatic set_dir(input int d);
    sm.dir_in = 2'(d);
    sm.dir_valid = 1'b1;
    tick();
    sm.dir_valid = 1'b0;
    if (d != (mdir ^ 1)) mpend = d;
  endtask

  task automatic set_food(input int f1, input int f2);
    sm.food1 = NL'(f1);
    sm.food2 = NL'(f2);
  endtask

  // One tick pulse; optionally a second pulse one cycle later while busy.
  task automatic do_step(input string tag, input bit second);
    bit live;
    live = !mdead;
    sm.step = 1'b1;
    tick();
    sm.step = 1'b0;
    chk({tag, ".busy1"}, sm.busy, live);
    if (second) sm.step = 1'b1;
    tick();
    sm.step = 1'b0;
    chk({tag, ".busy2"}, sm.busy, live);
    tick();
    m_move();
    check_state(tag, 1'b0);
    tick();
    exp_ate = 1'b0;
    chk({tag, ".ate_drop"}, sm.ate, 1'b0);
  endtask

  initial begin
    int nxt, sel;
    bit wl;
    sm.step = 1'b0; sm.dir_in = 2'b00; sm.dir_valid = 1'b0;
    set_food(1023, 1023);
    tick();
    do_reset();
    chk("reset.low30", sm.snake[29:0], {10'd202, 10'd203, 10'd204});

    do_step("plain", 1'b0);
    chk("plain.head", sm.snake[9:0], 10'd205);
    set_dir(2);
    do_step("reverse_ignored", 1'b0);
    chk("rev.head", sm.snake[9:0], 10'd206);

    set_food(207, 1023);
    do_step("eat", 1'b0);
    chk("eat.seg3", sm.snake[39:30], 10'd204);

    set_food(1023, 1023);
    do_step("double_step", 1'b1);
    chk("double.head", sm.snake[9:0], 10'd208);

    set_food(209, 209);
    do_step("eat_both", 1'b0);
    set_food(1023, 1023);
    set_dir(1); do_step("loop_down", 1'b0);
    set_dir(2); do_step("loop_left", 1'b0);
    set_dir(0); do_step("loop_up", 1'b0);
    chk("loop.dead", sm.dead, 1'b1);
    do_step("dead_step", 1'b0);

    // Run right into column 31, then one more move.
    do_reset();
    for (int i = 0; i < 19; i++) do_step("to_edge", 1'b0);
    chk("edge.head", sm.snake[9:0], 10'd223);
    do_step("edge", 1'b0);
    do_step("edge_after", 1'b0);

    // Eat on every move until the length saturates.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      nxt = m_next(mpend, wl);
      set_food(nxt, 1023);
      do_step("grow", 1'b0);
    end
    chk("sat.score", sm.score, 4'd15);
    set_food(1023, 1023);

    // Reset arriving while a move is in flight.
    sm.step = 1'b1; tick(); sm.step = 1'b0; tick();
    do_reset();

    for (int n = 0; n < 200; n++) begin
      if (mdead) do_reset();
      if ($urandom_range(0, 1) == 1) set_dir(int'($urandom_range(0, 3)));
      nxt = m_next(mpend, wl);
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: set_food(int'($urandom_range(0, 767)), int'($urandom_range(0, 767)));
        1: set_food(nxt, 1023);
        2: set_food(nxt, nxt);
        default: set_food(1023, 1023);
      endcase
      do_step("rnd", $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
